vga_pattern_gen: RTL
====================

Name: vga_pattern_gen

Overview:
- Video stage directly downstream of the sync/row-column counter stage.
- Consumes registered Hsync/Vsync plus col/row counts and produces 3-bit-per-channel RGB test patterns, with syncs delayed to stay aligned with the pixels.
- Pattern selection changes only at frame boundaries, so no torn frames.
- Includes a moving, bouncing square whose position updates once per frame.

Parameters:
- ACTIVE_COLS, 640, visible columns per line.
- ACTIVE_ROWS, 480, visible rows per frame.
- SQ_SIZE, 32, moving-square edge length in pixels.
- STEP, 2, square displacement per frame on each axis, in pixels.

Ports:
- clk_i  in  1  pixel clock
- rst_n_i  in  1  asynchronous active-low reset
- Hsync_i  in  1  horizontal sync from counter stage
- Vsync_i  in  1  vertical sync from counter stage
- col_count_i  in  10  current column, 0..TOTAL_COLS-1
- row_count_i  in  10  current row, 0..TOTAL_ROWS-1
- pattern_sel_i  in  3  requested pattern, asynchronous to frames
- Hsync_o  out  1  Hsync_i delayed 2 cycles
- Vsync_o  out  1  Vsync_i delayed 2 cycles
- red_o  out  3  red level
- grn_o  out  3  green level
- blu_o  out  3  blue level

Behaviour:
- Clock and reset: one clock domain (clk_i). Reset is asynchronous and active-low on rst_n_i.
- Reset values:
  - All outputs are 0.
  - Internal state: vsync_d=0, pattern_q=0, sq_x=0, sq_y=0, dir_x=+, dir_y=+, all pipeline registers 0.
  - Reset asserted mid-frame clears everything immediately. Output is black until the next frame start after release.
- Frame start: frame_start = Vsync_i & ~vsync_d, where vsync_d is Vsync_i registered once. It is a single-cycle pulse.
- On frame_start:
  - pattern_q <= pattern_sel_i.
  - The square position updates from its current value, in the same cycle.
- Pipeline: the latency is exactly 2 cycles for RGB, Hsync_o and Vsync_o.
  - Stage 1 registers the syncs, the counts and the active flag (col < ACTIVE_COLS && row < ACTIVE_ROWS).
  - Stage 2 registers the pattern result.
- Blanking: when the stage-1 active flag is 0, RGB = 0 regardless of pattern.
- Patterns (pattern_q):
  - 0: black.
  - 1: solid red, R=7 G=0 B=0.
  - 2: solid white, all channels 7.
  - 3: checkerboard. col[5]^row[5] = 1 gives white, otherwise black.
  - 4: 8 colour bars, each ACTIVE_COLS/8 wide (80 at default). bar = col/(ACTIVE_COLS/8), range 0..7. R = {3{bar[2]}}, G = {3{bar[1]}}, B = {3{bar[0]}}.
  - 5: moving square. Pixels with sq_x <= col < sq_x+SQ_SIZE and sq_y <= row < sq_y+SQ_SIZE are white. The background is blue: R=0 G=0 B=7.
  - 6, 7: black.
- Square motion, evaluated on frame_start only. The x-axis is described here; the y-axis is identical using ACTIVE_ROWS.
  - Moving +: if sq_x+STEP >= ACTIVE_COLS-SQ_SIZE, then sq_x <= ACTIVE_COLS-SQ_SIZE and dir_x <= −. Otherwise sq_x <= sq_x+STEP.
  - Moving −: if sq_x <= STEP, then sq_x <= 0 and dir_x <= +. Otherwise sq_x <= sq_x−STEP.
  - The square never leaves the active area. Arithmetic is 11 bits wide, so there is no wrap.
- Motion runs every frame regardless of pattern_q. Switching to pattern 5 shows the current position, not a reset position.
- Simultaneous events:
  - If pattern_sel_i changes in the same cycle as frame_start, the new value is captured.
  - Changes at any other time are ignored until the next frame start.
- Vsync held high continuously: exactly one frame_start, with no repeated motion steps.

Test Plan:
- Reset released, pattern_sel_i=2, then the first Vsync rising edge → output RGB=7/7/7 when active; when col_count_i=640 or row_count_i=480 → RGB=0 two cycles later.
- Latency check: Hsync_i toggles at cycle N → Hsync_o toggles at cycle N+2. The RGB change for col 0 appears at N+2 when col_count_i=0 at N.
- pattern_sel_i=4, row 10 → col 0–79 RGB=0/0/0, col 80 RGB=0/0/7, col 560–639 RGB=7/7/7.
- pattern_sel_i changes 3→1 mid-frame → output stays checkerboard (col 32,row 0 white; col 32,row 32 black) until the next Vsync rise, then is solid red.
- Pattern 5, run 305 frames → sq_x reaches 608 with dir_x flipped to −, then 606 on the next frame. sq_y reaches 448 at frame 225 and flips. Square pixels are white and the background is blue.
- Assert rst_n_i mid-line during pattern 5 → all outputs read 0 within the same cycle, and sq_x=sq_y=0 after release.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern stage that sits behind the sync/row-column counter stage.
//   Turns col/row counts into 3-bit-per-channel RGB and delays the syncs so
//   they stay aligned with the pixels (2-cycle latency on every output).
//   The selected pattern is latched only on a Vsync rising edge, so frames are
//   never torn. A bouncing square moves STEP pixels per frame on each axis.
//
// Ports
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset
//   Hsync_i        horizontal sync from counter stage
//   Vsync_i        vertical sync from counter stage
//   col_count_i    current column
//   row_count_i    current row
//   pattern_sel_i  requested pattern, sampled at frame start
//   Hsync_o        Hsync_i delayed 2 cycles
//   Vsync_o        Vsync_i delayed 2 cycles
//   red_o          red level
//   grn_o          green level
//   blu_o          blue level
module vga_pattern_gen #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int SQ_SIZE     = 32,
  parameter int STEP        = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       Hsync_i,
  input  logic       Vsync_i,
  input  logic [9:0] col_count_i,
  input  logic [9:0] row_count_i,
  input  logic [2:0] pattern_sel_i,
  output logic       Hsync_o,
  output logic       Vsync_o,
  output logic [2:0] red_o,
  output logic [2:0] grn_o,
  output logic [2:0] blu_o
);

  localparam logic [9:0]  COLS   = 10'(ACTIVE_COLS);
  localparam logic [9:0]  ROWS   = 10'(ACTIVE_ROWS);
  localparam logic [9:0]  BAR_W  = 10'(ACTIVE_COLS / 8);
  localparam logic [10:0] X_MAX  = 11'(ACTIVE_COLS - SQ_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(ACTIVE_ROWS - SQ_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] SQ_W   = 11'(SQ_SIZE);

  logic        vsync_d;
  logic        frame_start;
  logic [2:0]  pattern_q;
  logic [10:0] sq_x, sq_y;
  logic        dir_x_neg, dir_y_neg;
  logic [10:0] sq_x_nxt, sq_y_nxt;
  logic        dir_x_neg_nxt, dir_y_neg_nxt;

  logic        hs1, vs1, act1;
  logic [9:0]  col1, row1;

  logic [2:0]  pix_r, pix_g, pix_b;
  logic [2:0]  bar;
  logic [10:0] col1_w, row1_w;
  logic        in_sq;

  assign frame_start = Vsync_i & ~vsync_d;

  // Next square position; 11-bit math keeps sq+STEP from wrapping.
  always_comb begin
    sq_x_nxt      = sq_x;
    dir_x_neg_nxt = dir_x_neg;
    if (!dir_x_neg) begin
      if (sq_x + STEP_W >= X_MAX) begin
        sq_x_nxt      = X_MAX;
        dir_x_neg_nxt = 1'b1;
      end else begin
        sq_x_nxt = sq_x + STEP_W;
      end
    end else if (sq_x <= STEP_W) begin
      sq_x_nxt      = '0;
      dir_x_neg_nxt = 1'b0;
    end else begin
      sq_x_nxt = sq_x - STEP_W;
    end

    sq_y_nxt      = sq_y;
    dir_y_neg_nxt = dir_y_neg;
    if (!dir_y_neg) begin
      if (sq_y + STEP_W >= Y_MAX) begin
        sq_y_nxt      = Y_MAX;
        dir_y_neg_nxt = 1'b1;
      end else begin
        sq_y_nxt = sq_y + STEP_W;
      end
    end else if (sq_y <= STEP_W) begin
      sq_y_nxt      = '0;
      dir_y_neg_nxt = 1'b0;
    end else begin
      sq_y_nxt = sq_y - STEP_W;
    end
  end

  // Frame-level state: pattern latch and square motion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vsync_d   <= 1'b0;
      pattern_q <= '0;
      sq_x      <= '0;
      sq_y      <= '0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
    end else begin
      vsync_d <= Vsync_i;
      if (frame_start) begin
        pattern_q <= pattern_sel_i;
        sq_x      <= sq_x_nxt;
        sq_y      <= sq_y_nxt;
        dir_x_neg <= dir_x_neg_nxt;
        dir_y_neg <= dir_y_neg_nxt;
      end
    end
  end

  // Stage 1: syncs, counts and active flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      act1 <= 1'b0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      hs1  <= Hsync_i;
      vs1  <= Vsync_i;
      act1 <= (col_count_i < COLS) && (row_count_i < ROWS);
      col1 <= col_count_i;
      row1 <= row_count_i;
    end
  end

  assign col1_w = {1'b0, col1};
  assign row1_w = {1'b0, row1};
  assign bar    = 3'(col1 / BAR_W);
  assign in_sq  = (col1_w >= sq_x) && (col1_w < sq_x + SQ_W) &&
                  (row1_w >= sq_y) && (row1_w < sq_y + SQ_W);

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (act1) begin
      case (pattern_q)
        3'd1: pix_r = 3'd7;
        3'd2: begin
          pix_r = 3'd7;
          pix_g = 3'd7;
          pix_b = 3'd7;
        end
        3'd3: begin
          if (col1[5] ^ row1[5]) begin
            pix_r = 3'd7;
            pix_g = 3'd7;
            pix_b = 3'd7;
          end
        end
        3'd4: begin
          pix_r = {3{bar[2]}};
          pix_g = {3{bar[1]}};
          pix_b = {3{bar[0]}};
        end
        3'd5: begin
          pix_b = 3'd7;
          if (in_sq) begin
            pix_r = 3'd7;
            pix_g = 3'd7;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 2: pattern result and delayed syncs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      Hsync_o <= 1'b0;
      Vsync_o <= 1'b0;
      red_o   <= '0;
      grn_o   <= '0;
      blu_o   <= '0;
    end else begin
      Hsync_o <= hs1;
      Vsync_o <= vs1;
      red_o   <= pix_r;
      grn_o   <= pix_g;
      blu_o   <= pix_b;
    end
  end

endmodule
